// File: rtl/result_display.sv
// Binary-to-BCD converter (double dabble, one bit per clock) driving a 6-digit multiplexed 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 4..1 on the display only.
module result_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] RESULT,
  input  logic        NEG,
  input  logic        LOAD,
  output logic        BUSY,
  output logic        DONE,
  output logic [19:0] BCD,
  output logic [6:0]  SEG,
  output logic [5:0]  AN
);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  state_t        r_state, w_next;
  logic [15:0]   r_sr;
  logic [19:0]   r_acc, w_adj;
  logic [3:0]    r_step;
  logic          r_neg, r_sign, r_done;
  logic [19:0]   r_bcd;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic          w_start, w_fin, w_conv;
  logic [3:0]    w_nib;
  logic [7:0]    w_blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (LOAD) w_next = CONV;
      CONV:    if (r_step == 4'd15) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY    = (r_state != IDLE);
    w_start = (r_state == IDLE) && LOAD;
    w_conv  = (r_state == CONV);
    w_fin   = (r_state == FIN);
  end

  // add-3 correction so each nibble stays a valid decimal digit after the shift
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 5; i++)
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr   <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_neg  <= 1'b0;
      r_sign <= 1'b0;
      r_bcd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_sr   <= RESULT;
        r_neg  <= NEG;
        r_acc  <= '0;
        r_step <= '0;
      end else if (w_conv) begin
        {r_acc, r_sr} <= {w_adj[18:0], r_sr, 1'b0};
        r_step        <= r_step + 4'd1;
      end else if (w_fin) begin
        r_bcd  <= r_acc;
        r_sign <= r_neg;
        r_done <= 1'b1;
      end
    end
  end

  assign BCD  = r_bcd;
  assign DONE = r_done;

  // free-running digit scan, independent of the converter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    w_blank[4] = (r_bcd[19:16] == 4'd0);
    w_blank[3] = w_blank[4] && (r_bcd[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (r_bcd[11:8]  == 4'd0);
    w_blank[1] = w_blank[2] && (r_bcd[7:4]   == 4'd0);
`endif
  end

  always_comb begin
    w_nib = r_bcd[3:0];
    case (r_idx)
      3'd1:    w_nib = r_bcd[7:4];
      3'd2:    w_nib = r_bcd[11:8];
      3'd3:    w_nib = r_bcd[15:12];
      3'd4:    w_nib = r_bcd[19:16];
      default: w_nib = r_bcd[3:0];
    endcase
  end

  always_comb begin
    AN  = 6'b111111;
    SEG = 7'h00;
    if (r_idx <= 3'd5) AN = ~(6'b000001 << r_idx);
    if (r_idx == 3'd5)     SEG = r_sign ? 7'h40 : 7'h00;
    else if (r_idx < 3'd5) SEG = w_blank[r_idx] ? 7'h00 : seg7(w_nib);
  end

endmodule

// File: tb/tb_result_display.sv
// Randomized self-checking bench for result_display; reference model works on decimal values
// (division/modulo) and a free-running digit counter rather than on shift/add-3 steps.
module tb_result_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] RESULT = '0;
  logic        NEG = 1'b0;
  logic        LOAD = 1'b0;
  logic        BUSY, DONE;
  logic [19:0] BCD;
  logic [6:0]  SEG;
  logic [5:0]  AN;

  int checks = 0;
  int errors = 0;

  result_display #(.SCAN_DIV(1)) dut (
    .clk(clk), .reset(reset), .RESULT(RESULT), .NEG(NEG), .LOAD(LOAD),
    .BUSY(BUSY), .DONE(DONE), .BCD(BCD), .SEG(SEG), .AN(AN)
  );

  always #5 clk = ~clk;

  // reference model state
  bit m_busy, m_done, m_sign, pend_neg;
  int m_cnt, m_val, pend, m_idx;
  logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int P10 [5] = '{1, 10, 100, 1000, 10000};

  function automatic logic [19:0] exp_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / P10[k]) % 10);
    return r;
  endfunction

  function automatic logic [5:0] exp_an(input int idx);
    logic [5:0] a;
    a = 6'b111111;
    a[idx] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(input int idx);
    if (idx == 5) return m_sign ? 7'h40 : 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && m_val < P10[idx]) return 7'h00;
`endif
    return SEG_TAB[(m_val / P10[idx]) % 10];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_sign = 0; m_cnt = 0; m_val = 0; m_idx = 0;
  endtask

  // one clock: advance model at the edge, return at the following falling edge
  task automatic tick();
    @(posedge clk);
    m_done = 0;
    if (m_busy) begin
      m_cnt++;
      if (m_cnt == 17) begin
        m_busy = 0; m_val = pend; m_sign = pend_neg; m_done = 1;
      end
    end else if (LOAD) begin
      m_busy = 1; m_cnt = 0; pend = int'(RESULT); pend_neg = NEG;
    end
    m_idx = (m_idx + 1) % 6;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 0; LOAD = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
    end
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (BCD !== 20'h0) begin errors++; $display("FAIL reset_bcd: got %h want 00000", BCD); end
    checks++;
    if (AN !== 6'b111110) begin errors++; $display("FAIL reset_an: got %b want 111110", AN); end
    checks++;
    if (SEG !== 7'h3F) begin errors++; $display("FAIL reset_seg: got %h want 3f", SEG); end
  endtask

  task automatic test_max();
    int nb = 0, nd = 0;
    RESULT = 16'd65535; NEG = 0; LOAD = 1;
    tick();
    LOAD = 0;
    for (int c = 0; c < 25; c++) begin
      if (BUSY === 1'b1) nb++;
      if (DONE === 1'b1) nd++;
      checks++;
      if (BUSY !== m_busy || DONE !== m_done) begin
        errors++; $display("FAIL max_cycle%0d: BUSY=%b DONE=%b want %b %b", c, BUSY, DONE, m_busy, m_done);
      end
      tick();
    end
    checks++;
    if (nb != 17) begin errors++; $display("FAIL max_busy_len: got %0d want 17", nb); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL max_done_cnt: got %0d want 1", nd); end
    checks++;
    if (BCD !== 20'h65535) begin errors++; $display("FAIL max_bcd: got %h want 65535", BCD); end
  endtask

  task automatic test_scan();
    int seen = 0;
    RESULT = 16'd42; NEG = 1; LOAD = 1;
    tick();
    LOAD = 0;
    for (int c = 0; c < 30 && DONE !== 1'b1; c++) tick();
    checks++;
    if (DONE !== 1'b1) begin errors++; $display("FAIL scan_done: DONE=%b want 1", DONE); end
    for (int c = 0; c < 6; c++) begin
      tick();
      seen |= (1 << m_idx);
      checks++;
      if (AN !== exp_an(m_idx) || SEG !== exp_seg(m_idx)) begin
        errors++;
        $display("FAIL scan_digit%0d: AN=%b SEG=%h want %b %h", m_idx, AN, SEG, exp_an(m_idx), exp_seg(m_idx));
      end
    end
    checks++;
    if (seen != 63) begin errors++; $display("FAIL scan_coverage: got %b want 111111", seen[5:0]); end
  endtask

  task automatic test_ignored_load();
    int nd = 0;
    RESULT = 16'd1234; NEG = 0; LOAD = 1;
    tick();
    LOAD = 0;
    repeat (4) tick();
    RESULT = 16'd9999; LOAD = 1;
    tick();
    LOAD = 0;
    for (int c = 0; c < 25; c++) begin
      if (DONE === 1'b1) nd++;
      tick();
    end
    checks++;
    if (BCD !== 20'h01234) begin errors++; $display("FAIL ignored_bcd: got %h want 01234", BCD); end
    checks++;
    if (nd != 1) begin errors++; $display("FAIL ignored_done_cnt: got %0d want 1", nd); end
  endtask

  task automatic test_abort();
    int nd = 0;
    RESULT = 16'd500; NEG = 1; LOAD = 1;
    tick();
    LOAD = 0;
    repeat (7) tick();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    model_reset();
    for (int c = 0; c < 25; c++) begin
      if (DONE === 1'b1) nd++;
      tick();
    end
    checks++;
    if (nd != 0 || BCD !== 20'h0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL abort_state: dones=%0d BCD=%h BUSY=%b want 0 00000 0", nd, BCD, BUSY);
    end
    RESULT = 16'd7; NEG = 0; LOAD = 1;
    tick();
    LOAD = 0;
    repeat (20) tick();
    checks++;
    if (BCD !== 20'h00007) begin errors++; $display("FAIL abort_reload_bcd: got %h want 00007", BCD); end
  endtask

  task automatic test_zero();
    RESULT = 16'd0; NEG = 0; LOAD = 1;
    tick();
    LOAD = 0;
    repeat (20) tick();
    checks++;
    if (BCD !== 20'h0) begin errors++; $display("FAIL zero_bcd: got %h want 00000", BCD); end
    for (int c = 0; c < 6; c++) begin
      if (m_idx == 5) begin
        checks++;
        if (SEG !== 7'h00) begin errors++; $display("FAIL zero_sign_seg: got %h want 00", SEG); end
      end else if (m_idx == 0) begin
        checks++;
        if (SEG !== 7'h3F) begin errors++; $display("FAIL zero_ones_seg: got %h want 3f", SEG); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int nconv = 0;
    for (int c = 0; c < 600; c++) begin
      LOAD   = ($urandom_range(0, 3) == 0);
      RESULT = 16'($urandom);
      NEG    = 1'($urandom);
      if (LOAD && !m_busy) nconv++;
      tick();
      checks++;
      if (BUSY !== m_busy || DONE !== m_done || BCD !== exp_bcd(m_val) ||
          AN !== exp_an(m_idx) || SEG !== exp_seg(m_idx)) begin
        errors++;
        $display("FAIL random_cycle%0d: BUSY=%b DONE=%b BCD=%h AN=%b SEG=%h want %b %b %h %b %h",
                 c, BUSY, DONE, BCD, AN, SEG, m_busy, m_done, exp_bcd(m_val), exp_an(m_idx), exp_seg(m_idx));
      end
    end
    LOAD = 0;
    checks++;
    if (nconv < 10) begin errors++; $display("FAIL random_coverage: only %0d conversions", nconv); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_scan();
    test_ignored_load();
    test_abort();
    test_zero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
